// File: rtl/can_tx_arbiter.sv
// can_tx_arbiter: frame-atomic NREQ->1 arbiter feeding the CAN TX FIFO, truncating frames at MAXLEN.
// Grant 1 cycle after request, then zero-latency pass-through stalled by otready; CAN_TX_ARB_FIXED_PRIO_EN selects fixed priority.
module can_tx_arbiter #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8,
    parameter int MAXLEN = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic                     otvalid,
    input  logic                     otready,
    output logic [DWIDTH-1:0]        otdata,
    output logic [NREQ-1:0]          grant,
    output logic                     busy,
    output logic                     trunc
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAXLEN + 1);

    typedef enum logic [1:0] {IDLE, XFER, DROP} state_t;

    state_t             r_state, w_state_nxt;
    logic [IW-1:0]      r_gidx, w_gidx_nxt, w_win;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic               r_trunc, w_trunc_nxt;
    logic               w_found;
    logic [NREQ-1:0]    w_onehot;
    logic               w_vld, w_last;
    logic [DWIDTH-1:0]  w_data;
`ifndef CAN_TX_ARB_FIXED_PRIO_EN
    logic [IW-1:0]      r_last_gidx, w_last_nxt;
`endif

    assign w_onehot = NREQ'(1) << r_gidx;

    // Selected requester's byte, valid and last flag.
    always_comb begin
        w_vld  = 1'b0;
        w_last = 1'b0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gidx == IW'(i)) begin
                w_vld  = req_valid[i];
                w_last = req_last[i];
                w_data = req_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
`ifdef CAN_TX_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i]) begin
                w_found = 1'b1;
                w_win   = IW'(i);
            end
        end
`else
        // Round-robin: first look above the previous owner, then wrap to the lowest index.
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i] && (IW'(i) > r_last_gidx)) begin
                w_found = 1'b1;
                w_win   = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && req_valid[i]) begin
                w_found = 1'b1;
                w_win   = IW'(i);
            end
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gidx_nxt  = r_gidx;
        w_cnt_nxt   = r_cnt;
        w_trunc_nxt = 1'b0;
`ifndef CAN_TX_ARB_FIXED_PRIO_EN
        w_last_nxt  = r_last_gidx;
`endif
        req_ready   = '0;
        otvalid     = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_gidx_nxt  = w_win;
                    w_cnt_nxt   = '0;
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                otvalid   = w_vld;
                req_ready = w_onehot & {NREQ{otready}};
                if (w_vld && otready) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    // A last byte landing exactly on MAXLEN is a normal end, not a truncation.
                    if (w_last) begin
                        w_state_nxt = IDLE;
`ifndef CAN_TX_ARB_FIXED_PRIO_EN
                        w_last_nxt  = r_gidx;
`endif
                    end else if (r_cnt == CW'(MAXLEN - 1)) begin
                        w_state_nxt = DROP;
                        w_trunc_nxt = 1'b1;
`ifndef CAN_TX_ARB_FIXED_PRIO_EN
                        w_last_nxt  = r_gidx;
`endif
                    end
                end
            end
            DROP: begin
                req_ready = w_onehot;
                if (w_vld && w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_gidx      <= '0;
            r_cnt       <= '0;
            r_trunc     <= 1'b0;
`ifndef CAN_TX_ARB_FIXED_PRIO_EN
            r_last_gidx <= IW'(NREQ - 1);
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_gidx      <= w_gidx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_trunc     <= w_trunc_nxt;
`ifndef CAN_TX_ARB_FIXED_PRIO_EN
            r_last_gidx <= w_last_nxt;
`endif
        end
    end

    assign busy   = (r_state != IDLE);
    assign grant  = busy ? w_onehot : '0;
    assign trunc  = r_trunc;
    assign otdata = w_data;

endmodule

// File: tb/tb_can_tx_arbiter.sv
// Bench for can_tx_arbiter: arbitration vector table, hand-written frame corner cases,
// and randomized multi-requester traffic scored against a frame-level reference.
module tb_can_tx_arbiter;

    localparam int NREQ   = 4;
    localparam int DW     = 8;
    localparam int MAXLEN = 16;
    localparam int LIMIT  = 20000;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NREQ-1:0]      req_valid, req_ready, req_last, grant;
    logic [NREQ*DW-1:0]   req_data;
    logic                 otvalid, otready, busy, trunc;
    logic [DW-1:0]        otdata;

    int checks = 0;
    int errors = 0;

    can_tx_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .MAXLEN(MAXLEN)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_last(req_last),
        .otvalid(otvalid), .otready(otready), .otdata(otdata),
        .grant(grant), .busy(busy), .trunc(trunc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        return NREQ'(1) << i;
    endfunction

    function automatic logic [7:0] fbyte(input int k);
        return 8'(8'h30 + k);
    endfunction

    // Reference arbitration: first requesting index after the previous owner, modulo NREQ.
    function automatic int pick(input logic [NREQ-1:0] v, input int last);
`ifdef CAN_TX_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
        return -1;
    endfunction

    task automatic do_reset();
        rstn = 1'b0; req_valid = '0; req_last = '0; req_data = '0; otready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_otvalid", otvalid, 0);
        chk("rst_otdata", otdata, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_trunc", trunc, 0);
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    // Single requester sends one frame of len bytes; optional otready stall before byte stall_at.
    task automatic run_frame(input int r, input int len, input int stall_at, input int stall_cyc,
                             output int sent, output int fwd, output int ntr, output int ndrop,
                             output int bad, output int stall_bad, output int busy_after);
        int cyc = 0;
        int stalls = 0;
        sent = 0; fwd = 0; ntr = 0; ndrop = 0; bad = 0; stall_bad = 0;
        req_valid = oh(r);
        while (sent < len && cyc < 200) begin
            req_data[r*DW +: DW] = fbyte(sent);
            req_last = (sent == len - 1) ? oh(r) : '0;
            otready = !(sent == stall_at && busy && stalls < stall_cyc);
            @(negedge clk);
            if (trunc) ntr++;
            if (!otready) begin
                stalls++;
                if (otvalid !== 1'b1 || otdata !== fbyte(sent) || req_ready !== '0) stall_bad++;
            end
            if (req_valid[r] && req_ready[r]) begin
                if (otvalid) begin
                    fwd++;
                    if (otdata !== fbyte(sent)) bad++;
                end else begin
                    ndrop++;
                end
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        req_valid = '0; req_last = '0; otready = 1'b1;
        @(negedge clk);
        if (trunc) ntr++;
        busy_after = int'(busy);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [NREQ-1:0] vld;
        logic [NREQ-1:0] g_rr;
        logic [7:0]      d_rr;
        logic [NREQ-1:0] g_fx;
        logic [7:0]      d_fx;
    } vec_t;

    logic [8:0] src_q [NREQ][$];
    logic [7:0] exp_q [NREQ][$];

    function automatic int src_left();
        int n = 0;
        for (int r = 0; r < NREQ; r++) n += src_q[r].size();
        return n;
    endfunction

    initial begin
        vec_t vecs [8];
        logic [NREQ-1:0] eg;
        logic [7:0] ed;
        int sent, fwd, ntr, ndrop, bad, sbad, bafter;
        int owner, tb_last, pend, exp_trunc, seen_trunc, cyc, len;

        vecs[0] = '{4'b0001, 4'b0001, 8'hA0, 4'b0001, 8'hA0};
        vecs[1] = '{4'b1111, 4'b0010, 8'hA1, 4'b0001, 8'hA0};
        vecs[2] = '{4'b1001, 4'b1000, 8'hA3, 4'b0001, 8'hA0};
        vecs[3] = '{4'b1001, 4'b0001, 8'hA0, 4'b0001, 8'hA0};
        vecs[4] = '{4'b0001, 4'b0001, 8'hA0, 4'b0001, 8'hA0};
        vecs[5] = '{4'b0100, 4'b0100, 8'hA2, 4'b0100, 8'hA2};
        vecs[6] = '{4'b0011, 4'b0001, 8'hA0, 4'b0001, 8'hA0};
        vecs[7] = '{4'b1010, 4'b0010, 8'hA1, 4'b0010, 8'hA1};

        do_reset();

        // Single-byte frames: arbitration order from reset, one idle cycle between frames.
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_last = '1;
        otready  = 1'b1;
        for (int v = 0; v < 8; v++) begin
`ifdef CAN_TX_ARB_FIXED_PRIO_EN
            eg = vecs[v].g_fx; ed = vecs[v].d_fx;
`else
            eg = vecs[v].g_rr; ed = vecs[v].d_rr;
`endif
            req_valid = vecs[v].vld;
            @(negedge clk);
            chk($sformatf("vec%0d_idle_busy", v), busy, 0);
            chk($sformatf("vec%0d_idle_grant", v), grant, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("vec%0d_grant", v), grant, eg);
            chk($sformatf("vec%0d_otvalid", v), otvalid, 1);
            chk($sformatf("vec%0d_otdata", v), otdata, ed);
            chk($sformatf("vec%0d_ready", v), req_ready, eg);
            @(posedge clk); #1;
        end
        req_valid = '0; req_last = '0;

        // 3-byte frame from requester 0.
        req_valid = 4'b0001; req_data[7:0] = 8'h11; otready = 1'b1;
        @(negedge clk);
        chk("a_idle_grant", grant, 0);
        @(posedge clk); #1;
        for (int b = 0; b < 3; b++) begin
            req_data[7:0] = (b == 0) ? 8'h11 : (b == 1) ? 8'h22 : 8'h33;
            req_last = (b == 2) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            chk($sformatf("a_grant_b%0d", b), grant, 4'b0001);
            chk($sformatf("a_otvalid_b%0d", b), otvalid, 1);
            chk($sformatf("a_otdata_b%0d", b), otdata, req_data[7:0]);
            chk($sformatf("a_busy_b%0d", b), busy, 1);
            @(posedge clk); #1;
        end
        req_valid = '0; req_last = '0;
        @(negedge clk);
        chk("a_busy_after", busy, 0);
        chk("a_grant_after", grant, 0);
        @(posedge clk); #1;

        // 20-byte frame: 16 forwarded, 4 dropped, one trunc pulse.
        run_frame(2, 20, -1, 0, sent, fwd, ntr, ndrop, bad, sbad, bafter);
        chk("b_sent", sent, 20);
        chk("b_forwarded", fwd, MAXLEN);
        chk("b_dropped", ndrop, 4);
        chk("b_trunc", ntr, 1);
        chk("b_data", bad, 0);
        chk("b_busy_after", bafter, 0);

        // Exactly MAXLEN bytes: normal end.
        run_frame(1, 16, -1, 0, sent, fwd, ntr, ndrop, bad, sbad, bafter);
        chk("c_forwarded", fwd, 16);
        chk("c_dropped", ndrop, 0);
        chk("c_trunc", ntr, 0);
        chk("c_data", bad, 0);
        chk("c_busy_after", bafter, 0);

        // FIFO full for 5 cycles mid-frame; a MAXLEN frame exposes any count drift as a truncation.
        run_frame(3, 16, 2, 5, sent, fwd, ntr, ndrop, bad, sbad, bafter);
        chk("d_forwarded", fwd, 16);
        chk("d_stall_hold", sbad, 0);
        chk("d_trunc", ntr, 0);
        chk("d_dropped", ndrop, 0);
        chk("d_data", bad, 0);
        chk("d_busy_after", bafter, 0);

        // Reset after 2 of 5 bytes.
        req_valid = 4'b0010; req_last = '0; otready = 1'b1;
        req_data[15:8] = fbyte(0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_data[15:8] = fbyte(1);
        @(posedge clk); #1;
        req_data[15:8] = fbyte(2);
        @(negedge clk);
        chk("e_pre_grant", grant, 4'b0010);
        #2 rstn = 1'b0;
        #1;
        chk("e_rst_grant", grant, 0);
        chk("e_rst_busy", busy, 0);
        chk("e_rst_otvalid", otvalid, 0);
        chk("e_rst_ready", req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        req_valid = 4'b1111; req_last = '1;
        @(negedge clk);
        chk("e_post_grant", grant, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0; req_last = '0;
        @(posedge clk); #1;

        // Randomized traffic against a frame-level scoreboard.
        do_reset();
        exp_trunc = 0;
        for (int r = 0; r < NREQ; r++) begin
            for (int f = 0; f < 6; f++) begin
                len = $urandom_range(1, 20);
                if (len > MAXLEN) exp_trunc++;
                for (int k = 0; k < len; k++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    src_q[r].push_back({(k == len - 1), d});
                    if (k < MAXLEN) exp_q[r].push_back(d);
                end
            end
        end
        owner = -1; tb_last = NREQ - 1; pend = -1; seen_trunc = 0; cyc = 0;
        while ((src_left() > 0 || busy) && cyc < LIMIT) begin
            for (int r = 0; r < NREQ; r++) begin
                if (src_q[r].size() > 0) begin
                    req_valid[r] = ($urandom_range(0, 3) != 0);
                    req_data[r*DW +: DW] = src_q[r][0][7:0];
                    req_last[r] = src_q[r][0][8];
                end else begin
                    req_valid[r] = 1'b0;
                    req_last[r] = 1'b0;
                end
            end
            otready = ($urandom_range(0, 4) != 0);
            @(negedge clk);
            if (pend >= 0) begin
                chk("rnd_arb_grant", grant, oh(pend));
                owner = pend; tb_last = pend; pend = -1;
            end else if (busy && owner >= 0) begin
                chk("rnd_grant_hold", grant, oh(owner));
            end
            if (!busy) begin
                owner = -1;
                if (|req_valid) pend = pick(req_valid, tb_last);
            end
            if (req_ready & ~grant) chk("rnd_ready_ungranted", req_ready, req_ready & grant);
            if (trunc) seen_trunc++;
            for (int r = 0; r < NREQ; r++) begin
                if (req_valid[r] && req_ready[r]) begin
                    if (otvalid) begin
                        chk("rnd_fwd_owner", r, owner);
                        if (exp_q[r].size() == 0) begin
                            errors++; checks++;
                            $display("FAIL rnd_extra_byte: requester %0d forwarded 0x%0h, expected none", r, otdata);
                        end else begin
                            chk("rnd_fwd_data", otdata, exp_q[r].pop_front());
                        end
                    end
                    void'(src_q[r].pop_front());
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        req_valid = '0; req_last = '0;
        chk("rnd_finished_in_time", (cyc < LIMIT), 1);
        chk("rnd_trunc_count", seen_trunc, exp_trunc);
        for (int r = 0; r < NREQ; r++) chk($sformatf("rnd_missing_bytes_r%0d", r), exp_q[r].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/can_tx_arbiter.md
# can_tx_arbiter

Frame-atomic arbiter that shares one CAN TX byte-stream FIFO write port among NREQ requesters. A grant is held from a frame's first byte to its `req_last` byte, so bytes from different requesters never interleave in the FIFO. The block sits between the frame producers and the TX FIFO input (`itvalid`/`itready`/`itdata`). It enforces a maximum frame length by truncating the frame and discarding the requester's excess bytes.

## Interface
- NREQ, 4, number of requesters (2..16)
- DWIDTH, 8, byte-stream width
- MAXLEN, 16, maximum bytes forwarded per frame (2..255)

- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester byte valid
- req_ready  out  NREQ  per-requester byte accepted
- req_data  in  NREQ*DWIDTH  requester i at bits [i*DWIDTH +: DWIDTH]
- req_last  in  NREQ  per-requester last byte of frame
- otvalid  out  1  to FIFO itvalid
- otready  in  1  from FIFO itready
- otdata  out  DWIDTH  to FIFO itdata
- grant  out  NREQ  one-hot current owner; 0 when idle
- busy  out  1  state != IDLE
- trunc  out  1  one-cycle pulse when a frame is cut at MAXLEN

## Operation
- States: IDLE, XFER, DROP. Registers: `state`, `gidx`, `last_gidx`, `cnt`. `cnt` is ceil(log2(MAXLEN+1)) bits wide.
- IDLE:
  - If any `req_valid` is high, the winner is the first set bit scanning from `last_gidx+1` upward, mod NREQ.
  - The winner is registered into `gidx`, `cnt` is set to 0, and the next state is XFER.
  - `req_ready` is all 0 and `otvalid` is 0.
- XFER:
  - `otvalid = req_valid[gidx]`, `otdata = req_data[gidx]`, `req_ready[gidx] = otready`.
  - All other `req_ready` bits are 0.
  - A handshake is `req_valid[gidx] & otready`; each handshake increments `cnt`.
- XFER exit:
  - Handshake with `req_last[gidx]`: go to IDLE and set `last_gidx <= gidx`.
  - Handshake without last while `cnt == MAXLEN-1`: go to DROP, pulse `trunc` on the next cycle, and set `last_gidx <= gidx`.
  - If `req_last` and `cnt == MAXLEN-1` occur together, `req_last` wins: normal end, no `trunc`.
- DROP:
  - `req_ready[gidx] = 1` and `otvalid = 0`.
  - Bytes are consumed and discarded until a byte with `req_last[gidx]` is accepted, then go to IDLE.
- `req_valid` deasserting mid-frame does not release the grant. The arbiter waits indefinitely.
- `grant = busy ? onehot(gidx) : 0`.

## Timing
- Reset values:
  - `state` = IDLE, `gidx` = 0, `last_gidx` = NREQ-1 (requester 0 has first priority), `cnt` = 0.
  - All outputs are 0: `req_ready`, `otvalid`, `otdata`, `grant`, `busy`, `trunc`.
- Arbitration latency: a request seen in IDLE in cycle N gives `grant` and `otvalid` in cycle N+1.
- Throughput: 1 byte/cycle within a frame. There is a minimum of 1 IDLE bubble cycle between frames.
- Data path is combinational from the granted requester to the FIFO. There is no added latency within XFER.
- FIFO full (`otready = 0`): the byte is held, `cnt` is unchanged, and the granted `req_ready` is 0.
- Reset asserted mid-frame: outputs clear immediately (asynchronous). The partial frame already in the FIFO is the owner's responsibility.
- `otdata` is don't-care when `otvalid = 0`, but is driven from `req_data[gidx]`.

## Configuration
- CAN_TX_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority; the lowest index with `req_valid` wins in IDLE, and `last_gidx` is unused.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Reset, then `req_valid` = 4'b0001 with a 3-byte frame 0x11, 0x22, 0x33 and `otready` = 1 -> `grant` = 4'b0001 one cycle later; FIFO receives 0x11, 0x22, 0x33 on consecutive cycles; `busy` falls after the last byte.
- All four requesters continuously send 2-byte frames -> grant order 0, 1, 2, 3, 0; no interleaved bytes; 1 idle cycle between frames. With CAN_TX_ARB_FIXED_PRIO_EN defined -> requester 0 is granted every frame.
- Requester 2 sends 20 bytes with last on byte 20, MAXLEN = 16 -> FIFO receives exactly 16 bytes; `trunc` pulses once; bytes 17-20 are accepted and dropped; then IDLE.
- Frame of exactly 16 bytes with last on byte 16 -> 16 bytes forwarded, no `trunc`, no DROP.
- `otready` held 0 for 5 cycles mid-frame -> `otdata` stable, granted `req_ready` = 0, `cnt` unchanged; transfer resumes without loss.
- `rstn` asserted after 2 of 5 bytes -> `grant`, `busy`, `otvalid` are 0 immediately; after release, requester 0 is arbitrated first.
